// File: rtl/avmm_avst_bridge_pkg.sv
// Shared definitions for the AVMM <-> AVST tunnel.
//   BE_FULL / BE_LO / BE_HI : the only byteenable patterns with a defined meaning
//   IS_READ_OFS / IS_32BIT_OFS : flag bit positions counted down from the command MSB
//   pack_cmd : builds {is_read, is_32bit, addr, data} with addr zero-extended to
//              PACK_ADDR_MAX bits; users keep only the low addr bits they need.
package avmm_avst_bridge_pkg;

  localparam logic [7:0] BE_FULL = 8'hFF;
  localparam logic [7:0] BE_LO   = 8'h0F;
  localparam logic [7:0] BE_HI   = 8'hF0;

  localparam int IS_READ_OFS  = 0;
  localparam int IS_32BIT_OFS = 1;

  localparam int PACK_ADDR_MAX = 64;
  localparam int PACK_DATA_W   = 64;
  localparam int PACK_W        = PACK_ADDR_MAX + PACK_DATA_W + 2;

  function automatic logic [PACK_W-1:0] pack_cmd(
    input logic                     is_read,
    input logic                     is_32bit,
    input logic [PACK_ADDR_MAX-1:0] addr,
    input logic [PACK_DATA_W-1:0]   data
  );
    return {is_read, is_32bit, addr, data};
  endfunction

endpackage

// File: rtl/avst_cmd_fifo2.sv
// Generic 2-entry FIFO, head always in entry 0.
//   clk, rst_n : clock, asynchronous active-low reset (entries clear to zero)
//   push_i     : write din_i (ignored when full)
//   pop_i      : drop head (ignored when empty)
//   dout_o     : head entry
//   count_o    : occupancy 0..2
module avst_cmd_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    pop_ok   = pop_i && (count_q != 2'd0);
    push_ok  = push_i && (count_q != 2'd2);

    // Shift on pop so the head never moves; stale entry 1 is harmless.
    if (pop_ok) begin
      mem_d[0] = mem_q[1];
    end

    // Push lands in the first free slot as seen after this cycle's pop.
    if (push_ok) begin
      if (pop_ok ? (count_q == 2'd2) : (count_q == 2'd1)) begin
        mem_d[1] = din_i;
      end else begin
        mem_d[0] = din_i;
      end
    end

    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/avmm_slave_to_avst.sv
// Avalon-MM slave that turns single-beat reads/writes into packed AVST commands
// {is_read, is_32bit, addr, write_data} and returns read data from an AVST
// response stream.
//   clk, reset_n           : clock, asynchronous active-low reset
//   avs_*                  : AVMM slave port (waitrequest-based flow control)
//   cmd_data/valid/ready   : command stream towards the AVST-to-AVMM bridge
//   rsp_data/valid         : read responses (no backpressure)
//   be_error, rsp_error    : sticky error flags, cleared only by reset
module avmm_slave_to_avst
  import avmm_avst_bridge_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH   = 18,
  parameter int AVMM_DATA_WIDTH   = 64,
  parameter int MAX_PENDING_READS = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [AVMM_ADDR_WIDTH-1:0]   avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [AVMM_DATA_WIDTH-1:0]   avs_writedata,
  input  logic [7:0]                   avs_byteenable,
  output logic                         avs_waitrequest,
  output logic [AVMM_DATA_WIDTH-1:0]   avs_readdata,
  output logic                         avs_readdatavalid,
  output logic [AVMM_ADDR_WIDTH+65:0]  cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  input  logic [AVMM_DATA_WIDTH-1:0]   rsp_data,
  input  logic                         rsp_valid,
  output logic                         be_error,
  output logic                         rsp_error
);

  localparam int AW    = AVMM_ADDR_WIDTH;
  localparam int DW    = AVMM_DATA_WIDTH;
  localparam int CMD_W = AW + DW + 2;
  localparam int PW    = $clog2(MAX_PENDING_READS + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING_READS);

  typedef struct packed {
    logic          is_read;
    logic          is_32bit;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t              cmd_in;
  logic [PACK_W-1:0] packed_cmd;
  logic [AW-1:0]     addr_fix;
  logic              is_32bit;
  logic              be_legal;
  logic              accept;
  logic              rd_accept;
  logic              rsp_expected;
  logic [1:0]        fifo_count;
  logic [CMD_W-1:0]  fifo_head;

  logic [PW-1:0]     pend_q, pend_d;
  logic              be_err_q, be_err_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rdv_q;
  logic [DW-1:0]     rdata_q;

  // Registered state only (plus reset), so no combinational path from the
  // downstream ready/valid inputs back to the AVMM master.
  assign avs_waitrequest = !reset_n || (fifo_count == 2'd2) || (pend_q == PEND_MAX);

  assign accept       = (avs_read || avs_write) && !avs_waitrequest;
  assign rd_accept    = accept && avs_read;  // read wins when both are asserted
  assign rsp_expected = pend_q != '0;

  always_comb begin
    addr_fix = avs_address;
    is_32bit = 1'b0;
    be_legal = 1'b1;
    case (avs_byteenable)
      BE_FULL: ;
      BE_LO: begin
        is_32bit    = 1'b1;
        addr_fix[2] = 1'b0;
      end
      BE_HI: begin
        is_32bit    = 1'b1;
        addr_fix[2] = 1'b1;
      end
      default: be_legal = 1'b0;
    endcase
  end

  assign packed_cmd = pack_cmd(avs_read, is_32bit, PACK_ADDR_MAX'(addr_fix),
                               PACK_DATA_W'(avs_writedata));

  assign cmd_in.is_read  = packed_cmd[PACK_W-1-IS_READ_OFS];
  assign cmd_in.is_32bit = packed_cmd[PACK_W-1-IS_32BIT_OFS];
  assign cmd_in.addr     = packed_cmd[PACK_DATA_W +: AW];
  assign cmd_in.data     = DW'(packed_cmd[PACK_DATA_W-1:0]);

  // Upper address bits of the generic pack are always zero here.
  if (AW < PACK_ADDR_MAX) begin : gen_pack_unused
    logic unused_pack_bits;
    assign unused_pack_bits = ^packed_cmd[PACK_W-3:PACK_DATA_W+AW];
  end

  avst_cmd_fifo2 #(
    .W(CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (accept),
    .pop_i   (cmd_valid && cmd_ready),
    .din_i   (cmd_in),
    .dout_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign cmd_valid = fifo_count != 2'd0;
  assign cmd_data  = fifo_head;

  always_comb begin
    pend_d    = pend_q + PW'(rd_accept) - PW'(rsp_valid && rsp_expected);
    be_err_d  = be_err_q || (accept && ((avs_read && avs_write) || !be_legal));
    rsp_err_d = rsp_err_q || (rsp_valid && !rsp_expected);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= '0;
      be_err_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      be_err_q  <= be_err_d;
      rsp_err_q <= rsp_err_d;
      rdv_q     <= rsp_valid && rsp_expected;
      if (rsp_valid) begin
        rdata_q <= rsp_data;
      end
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rdv_q;
  assign be_error          = be_err_q;
  assign rsp_error         = rsp_err_q;

endmodule

// File: tb/tb_avmm_slave_to_avst.sv
module tb_avmm_slave_to_avst;

  localparam int AW   = 18;
  localparam int MAXP = 8;
  localparam int CW   = AW + 66;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [63:0]   avs_writedata;
  logic [7:0]    avs_byteenable;
  logic          avs_waitrequest;
  logic [63:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic [CW-1:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [63:0]   rsp_data;
  logic          rsp_valid;
  logic          be_error;
  logic          rsp_error;

  avmm_slave_to_avst #(
    .AVMM_ADDR_WIDTH(AW),
    .AVMM_DATA_WIDTH(64),
    .MAX_PENDING_READS(MAXP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .cmd_data          (cmd_data),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .rsp_data          (rsp_data),
    .rsp_valid         (rsp_valid),
    .be_error          (be_error),
    .rsp_error         (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: queue of commands awaiting pickup, number of reads
  // still owed a response, sticky flags and the last returned read.
  logic [CW-1:0] mq[$];
  int            mpend;
  bit            mbe, mrsp, mrdv;
  logic [63:0]   mrdata;
  int            n_checks, n_pass;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    mpend  = 0;
    mbe    = 0;
    mrsp   = 0;
    mrdv   = 0;
    mrdata = '0;
  endtask

  function automatic bit model_wait();
    return !reset_n || (mq.size() == 2) || (mpend == MAXP);
  endfunction

  function automatic logic [CW-1:0] expected_cmd();
    logic [AW-1:0] a;
    bit            is32;
    a    = avs_address;
    is32 = 0;
    if (avs_byteenable == 8'h0F) begin is32 = 1; a[2] = 1'b0; end
    if (avs_byteenable == 8'hF0) begin is32 = 1; a[2] = 1'b1; end
    return {avs_read, is32, a, avs_writedata};
  endfunction

  // Applies the effect of one rising edge to the model using the inputs
  // that were stable across that edge.
  task automatic model_edge();
    bit acc, legal, owed;
    if (!reset_n) begin
      model_clear();
      return;
    end
    acc   = (avs_read || avs_write) && !model_wait();
    legal = (avs_byteenable == 8'hFF) || (avs_byteenable == 8'h0F) || (avs_byteenable == 8'hF0);
    owed  = mpend > 0;
    if (mq.size() > 0 && cmd_ready) void'(mq.pop_front());
    if (acc) mq.push_back(expected_cmd());
    if (acc && ((avs_read && avs_write) || !legal)) mbe = 1;
    mrdv = rsp_valid && owed;
    if (mrdv) mrdata = rsp_data;
    if (rsp_valid && !owed) mrsp = 1;
    mpend = mpend + ((acc && avs_read) ? 1 : 0) - (mrdv ? 1 : 0);
  endtask

  task automatic check_all();
    chk("waitrequest", avs_waitrequest, model_wait());
    chk("cmd_valid", cmd_valid, mq.size() > 0);
    if (mq.size() > 0) chk("cmd_data", cmd_data, mq[0]);
    chk("readdatavalid", avs_readdatavalid, mrdv);
    if (mrdv) chk("readdata", avs_readdata, mrdata);
    chk("be_error", be_error, mbe);
    chk("rsp_error", rsp_error, mrsp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic setin(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [63:0] wd, input logic [7:0] be);
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = a;
    avs_writedata  = wd;
    avs_byteenable = be;
  endtask

  task automatic idle();
    setin(0, 0, '0, '0, 8'hFF);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    idle();
    model_clear();

    // Reset state
    repeat (3) tick();
    chk("rst_wait", avs_waitrequest, 1'b1);
    chk("rst_cmd_data", cmd_data, '0);
    chk("rst_readdata", avs_readdata, '0);
    reset_n = 1'b1;

    // Full-width write passes straight through with one cycle of latency
    cmd_ready = 1'b1;
    setin(0, 1, 18'h00010, 64'h1122334455667788, 8'hFF);
    tick();
    chk("t1_valid", cmd_valid, 1'b1);
    chk("t1_data", cmd_data, {1'b0, 1'b0, 18'h00010, 64'h1122334455667788});
    chk("t1_wait", avs_waitrequest, 1'b0);
    idle();
    tick();

    // Upper-half read and its response
    setin(1, 0, 18'h00008, 64'h0, 8'hF0);
    tick();
    chk("t2_flags", cmd_data[CW-1 -: 2], 2'b11);
    chk("t2_addr", cmd_data[64 +: AW], 18'h0000C);
    idle();
    rsp_valid = 1'b1;
    rsp_data  = 64'hDEADBEEF00000000;
    tick();
    chk("t2_rdv", avs_readdatavalid, 1'b1);
    chk("t2_rdata", avs_readdata, 64'hDEADBEEF00000000);
    rsp_valid = 1'b0;
    tick();
    chk("t2_rdv_low", avs_readdatavalid, 1'b0);

    // Backpressure: two accepted, third held until the first pop
    cmd_ready = 1'b0;
    setin(0, 1, 18'h100, 64'hAAAA, 8'hFF);
    tick();
    setin(0, 1, 18'h108, 64'hBBBB, 8'hFF);
    tick();
    chk("t3_wait_full", avs_waitrequest, 1'b1);
    setin(0, 1, 18'h110, 64'hCCCC, 8'hFF);
    tick();
    chk("t3_wait_held", avs_waitrequest, 1'b1);
    cmd_ready = 1'b1;
    tick();
    chk("t3_wait_free", avs_waitrequest, 1'b0);
    chk("t3_head_b", cmd_data[63:0], 64'hBBBB);
    tick();
    chk("t3_head_c", cmd_data[63:0], 64'hCCCC);
    idle();
    tick();

    // Outstanding read limit
    setin(1, 0, 18'h20, 64'h0, 8'hFF);
    repeat (MAXP) tick();
    chk("t4_limit", avs_waitrequest, 1'b1);
    tick();
    chk("t4_stall", avs_waitrequest, 1'b1);
    rsp_valid = 1'b1;
    rsp_data  = {$urandom(), $urandom()};
    tick();
    chk("t4_release", avs_waitrequest, 1'b0);
    chk("t4_rdv", avs_readdatavalid, 1'b1);
    rsp_valid = 1'b0;
    tick();
    chk("t4_refill", avs_waitrequest, 1'b1);
    idle();
    for (int i = 0; i < MAXP; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = {$urandom(), $urandom()};
      tick();
    end
    rsp_valid = 1'b0;
    tick();

    // Illegal byteenable, then an unsolicited response
    setin(0, 1, 18'h40, {$urandom(), $urandom()}, 8'h3C);
    tick();
    chk("t5_is32", cmd_data[CW-2], 1'b0);
    chk("t5_be_error", be_error, 1'b1);
    idle();
    tick();
    rsp_valid = 1'b1;
    tick();
    chk("t5_rdv", avs_readdatavalid, 1'b0);
    chk("t5_rsp_error", rsp_error, 1'b1);
    rsp_valid = 1'b0;

    // Asynchronous reset with work in flight
    setin(1, 0, 18'h80, 64'h0, 8'hFF);
    repeat (3) tick();
    idle();
    tick();
    cmd_ready = 1'b0;
    setin(0, 1, 18'h88, 64'h1234, 8'hFF);
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("t6_wait", avs_waitrequest, 1'b1);
    chk("t6_valid", cmd_valid, 1'b0);
    chk("t6_data", cmd_data, '0);
    chk("t6_rdv", avs_readdatavalid, 1'b0);
    chk("t6_rdata", avs_readdata, '0);
    chk("t6_be", be_error, 1'b0);
    chk("t6_rsp", rsp_error, 1'b0);
    idle();
    tick();
    reset_n   = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 64'h5555;
    tick();
    chk("t6_late_rsp", rsp_error, 1'b1);
    chk("t6_late_rdv", avs_readdatavalid, 1'b0);
    rsp_valid = 1'b0;
    tick();

    // Randomized traffic
    reset_n = 1'b0;
    model_clear();
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [7:0] be;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0, 1, 2: be = 8'hFF;
        3, 4:    be = 8'h0F;
        5, 6:    be = 8'hF0;
        default: be = 8'($urandom());
      endcase
      setin(r < 30 || r >= 97, r >= 30, 18'($urandom()), {$urandom(), $urandom()}, be);
      cmd_ready = $urandom_range(0, 3) != 0;
      rsp_valid = (mpend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      rsp_data  = {$urandom(), $urandom()};
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avmm_slave_to_avst.md
# avmm_slave_to_avst

Avalon-MM slave that converts single-beat read/write requests into the packed Avalon-ST command stream {is_read, is_32bit, addr, write_data}. It returns read responses from an Avalon-ST response stream as `readdata`/`readdatavalid`. It is the initiator end of the AVST-to-AVMM tunnel: it sits on the host/CSR side, and the AVST-to-AVMM slave bridge executes its commands against the target AVMM fabric.

## Interface
Parameters:
- AVMM_ADDR_WIDTH, 18, byte address width; bits [2:0] select the byte within a 64-bit word.
- AVMM_DATA_WIDTH, 64, data width; fixed at 64 (byteenable decode is 8-bit).
- MAX_PENDING_READS, 8, maximum number of accepted reads without a response; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  AVMM_ADDR_WIDTH  byte address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  64  write data.
- avs_byteenable  in  8  byte enables.
- avs_waitrequest  out  1  request stall.
- avs_readdata  out  64  read data.
- avs_readdatavalid  out  1  read data valid.
- cmd_data  out  AVMM_ADDR_WIDTH+66  packed command, MSB first: is_read, is_32bit, addr, write_data.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  command accepted by the downstream bridge.
- rsp_data  in  64  read response data.
- rsp_valid  in  1  response valid; this input cannot be backpressured.
- be_error  out  1  sticky flag: an illegal byteenable pattern was seen.
- rsp_error  out  1  sticky flag: a response arrived with no read pending.

## Operation
- **Acceptance.** A request is accepted in any cycle where (avs_read|avs_write) && !avs_waitrequest. If both avs_read and avs_write are high, the request is treated as a read and be_error is set.
- **Byteenable decode:**
  - 0xFF → is_32bit=0; address passed unchanged.
  - 0x0F → is_32bit=1; addr[2] forced to 0.
  - 0xF0 → is_32bit=1; addr[2] forced to 1.
  - Any other pattern (including 0x00) → is_32bit=0, be_error set, command still forwarded.
- **Read commands.** write_data field carries avs_writedata unmodified; it is don't-care for reads but must be driven deterministically.
- **Command queue.** 2-entry FIFO; cmd_valid = queue not empty. cmd_data is the head entry. A pop occurs on cmd_valid && cmd_ready.
- **avs_waitrequest** = !reset_n | (queue count==2) | (pending==MAX_PENDING_READS). It is a function of registered state only; there is no combinational path from cmd_ready or rsp_valid.
- **Pending read counter.** Width $clog2(MAX_PENDING_READS+1).
  - +1 on an accepted read.
  - −1 on rsp_valid while pending>0.
  - Both in the same cycle → unchanged.
  - rsp_valid with pending==0 → response dropped, rsp_error set, counter stays 0.
- **Read return.** avs_readdata <= rsp_data and avs_readdatavalid <= rsp_valid && pending>0, registered. Responses return in order.
- **Sticky flags.** be_error and rsp_error clear only on reset.
- **Reset mid-operation.** Queued commands, pending count and flags are discarded. Responses arriving after reset are treated as unexpected.

## Timing
- Reset values: avs_waitrequest=1, cmd_valid=0, cmd_data=0, avs_readdatavalid=0, avs_readdata=0, be_error=0, rsp_error=0.
- Command latency: a request accepted in cycle N appears on cmd_valid in cycle N+1 when the queue was empty.
- Throughput: with cmd_ready held high, the block accepts one request per cycle indefinitely.
- Backpressure: with cmd_ready low, two requests are accepted, then avs_waitrequest rises in the cycle after the second acceptance. It falls in the cycle after the first pop.
- Simultaneous push and pop with count==2 is impossible, because waitrequest is high.
- Simultaneous push and pop with count==1 leaves count at 1.
- Response latency: rsp_valid in cycle N → avs_readdatavalid in cycle N+1.
- Read limit: with pending==MAX_PENDING_READS, waitrequest is high. It deasserts in the cycle after a response decrements the counter.

## Structure
- Package avmm_avst_bridge_pkg holds:
  - BE_FULL=8'hFF, BE_LO=8'h0F, BE_HI=8'hF0;
  - the field-position constants IS_READ_OFS and IS_32BIT_OFS relative to the command MSB;
  - a function that packs {is_read, is_32bit, addr, data}.
- The packed command struct is declared locally, because it depends on module parameters.
- Sub-module avst_cmd_fifo2 is a generic 2-entry, parameter-width FIFO. It exposes push, pop, head data, count, and an asynchronous active-low reset.

## Test plan
- Write 0x1122334455667788 to 0x00010, BE=0xFF, cmd_ready=1 → cmd_data={0,0,0x00010,0x1122334455667788}, cmd_valid at N+1; no waitrequest.
- Read 0x00008 with BE=0xF0 → command {1,1,0x0000C,…}. Then rsp_valid with 0xDEADBEEF00000000 → avs_readdatavalid one cycle later with that data; pending returns to 0.
- cmd_ready=0 and 3 back-to-back writes → 2 accepted, waitrequest high from the cycle after the 2nd acceptance. Raise cmd_ready → commands emerge in order, and the 3rd write is accepted after the first pop.
- MAX_PENDING_READS=8, issue 9 reads with no responses → 8 accepted, 9th stalled. Return one response → 9th accepted in the following cycle.
- BE=0x3C write → forwarded with is_32bit=0, be_error=1. Then rsp_valid with pending=0 → no readdatavalid, rsp_error=1.
- Assert reset_n low with 2 queued commands and 3 pending reads → all outputs reach their reset values immediately (asynchronously). After release, a response is flagged by rsp_error.
